// File: rtl/vid_pkg.sv
// Shared types for the AXI4-Stream video output path.
// Beat layout stored in the FIFO and default raster geometry.
package vid_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    HUNT,
    FILL,
    RUN
  } vout_state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    rgb_t pix;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic int span(
    input int act,
    input int fp,
    input int sy,
    input int bp
  );
    return act + fp + sy + bp;
  endfunction

  localparam int H_TOTAL = span(800, 40, 128, 88);
  localparam int V_TOTAL = span(480, 13, 3, 29);

endpackage

// File: rtl/fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// soft_rst empties it without touching the stored words.
module fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       soft_rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (soft_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (rd_ok) rd_ptr <= nxt(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster position counters and sync/active decode.
// Counters sit at (0,0) whenever the raster is not running.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic pix_ce,
  output logic step,
  output logic active,
  output logic hs_on,
  output logic vs_on,
  output logic sof_pos,
  output logic eol_pos,
  output logic frame_end
);

  localparam int HT = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;

  logic [HW-1:0] hx;
  logic [VW-1:0] vy;
  logic          line_end;

  assign step      = run & pix_ce;
  assign line_end  = (hx == HW'(HT - 1));
  assign frame_end = line_end & (vy == VW'(VT - 1));
  assign active    = (hx < HW'(H_ACTIVE))
                   & (vy < VW'(V_ACTIVE));
  assign hs_on     = (hx >= HW'(HS0))
                   & (hx < HW'(HS0 + H_SYNC));
  assign vs_on     = (vy >= VW'(VS0))
                   & (vy < VW'(VS0 + V_SYNC));
  assign sof_pos   = (hx == '0) & (vy == '0);
  assign eol_pos   = (hx == HW'(H_ACTIVE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hx <= '0;
      vy <= '0;
    end else if (!run) begin
      hx <= '0;
      vy <= '0;
    end else if (step) begin
      if (line_end) begin
        hx <= '0;
        vy <= frame_end ? '0 : vy + 1'b1;
      end else begin
        hx <= hx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_vid_out.sv
// AXI4-Stream RGB sink regenerating HSYNC/VSYNC/DE raster timing.
// Locks to SOF, flags underflow/structure errors, resyncs at frame end.
module axis_vid_out
  import vid_pkg::*;
#(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 40,
  parameter int   H_SYNC     = 128,
  parameter int   H_BP       = 88,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 13,
  parameter int   V_SYNC     = 3,
  parameter int   V_BP       = 29,
  parameter bit   HS_POL     = 1'b0,
  parameter bit   VS_POL     = 1'b0,
  parameter int   FIFO_SIZE  = 1024,
  parameter int   LOCK_LEVEL = 512,
  parameter rgb_t UF_COLOR   = 24'hFF00FF
) (
  input  logic        AXIS_VID_ACLK,
  input  logic        AXIS_VID_ARESETN,
  input  logic [23:0] AXIS_VID_TDATA,
  input  logic        AXIS_VID_TLAST,
  input  logic        AXIS_VID_TUSER,
  input  logic        AXIS_VID_TVALID,
  output logic        AXIS_VID_TREADY,
  input  logic        PIX_CE,
  input  logic        CLR_ERR,
  output logic [23:0] VID_DATA,
  output logic        VID_HSYNC,
  output logic        VID_VSYNC,
  output logic        VID_DE,
  output logic        LOCKED,
  output logic        UNDERFLOW,
  output logic        FRAME_ERR
);

  localparam int CW = $clog2(FIFO_SIZE + 1);

  vout_state_t   state;
  vout_state_t   state_n;
  beat_t         wr_beat;
  beat_t         head;
  logic          push;
  logic          pop;
  logic          soft_rst;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          run;
  logic          step;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic          sof_pos;
  logic          eol_pos;
  logic          frame_end;
  logic          pix_evt;
  logic          uf_evt;
  logic          fe_evt;
  logic          resync_pend;

  assign wr_beat = '{sof: AXIS_VID_TUSER,
                     eol: AXIS_VID_TLAST,
                     pix: AXIS_VID_TDATA};

  fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_SIZE)
  ) u_fifo (
    .clk      (AXIS_VID_ACLK),
    .rst_n    (AXIS_VID_ARESETN),
    .soft_rst (soft_rst),
    .wr_en    (push),
    .wr_data  (wr_beat),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  vid_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (AXIS_VID_ACLK),
    .rst_n     (AXIS_VID_ARESETN),
    .run       (run),
    .pix_ce    (PIX_CE),
    .step      (step),
    .active    (active),
    .hs_on     (hs_on),
    .vs_on     (vs_on),
    .sof_pos   (sof_pos),
    .eol_pos   (eol_pos),
    .frame_end (frame_end)
  );

  assign run     = (state == RUN);
  assign LOCKED  = run;
  assign pix_evt = step & active;
  assign pop     = pix_evt & ~empty;
  assign uf_evt  = pix_evt & empty;
  assign fe_evt  = pop & ((head.sof != sof_pos)
                        | (head.eol != eol_pos));

  always_comb begin
    state_n         = state;
    AXIS_VID_TREADY = 1'b0;
    push            = 1'b0;
    soft_rst        = 1'b0;
    unique case (state)
      HUNT: begin
        AXIS_VID_TREADY = 1'b1;
        if (AXIS_VID_TVALID && AXIS_VID_TUSER) begin
          push    = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        AXIS_VID_TREADY = ~full;
        push = AXIS_VID_TVALID & ~full;
        if (count >= CW'(LOCK_LEVEL)) state_n = RUN;
      end
      RUN: begin
        AXIS_VID_TREADY = ~full;
        push = AXIS_VID_TVALID & ~full;
        // a pending resync only lands on the last pixel of the frame
        if (step && frame_end && resync_pend) begin
          soft_rst = 1'b1;
          state_n  = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
    if (!AXIS_VID_ARESETN) state <= HUNT;
    else state <= state_n;
  end

  always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
    if (!AXIS_VID_ARESETN) begin
      VID_DATA  <= '0;
      VID_DE    <= 1'b0;
      VID_HSYNC <= ~HS_POL;
      VID_VSYNC <= ~VS_POL;
    end else if (!run) begin
      VID_DATA  <= '0;
      VID_DE    <= 1'b0;
      VID_HSYNC <= ~HS_POL;
      VID_VSYNC <= ~VS_POL;
    end else if (step) begin
      VID_DE    <= active;
      VID_HSYNC <= hs_on ? HS_POL : ~HS_POL;
      VID_VSYNC <= vs_on ? VS_POL : ~VS_POL;
      unique case (1'b1)
        active & empty:  VID_DATA <= UF_COLOR;
        active & ~empty: VID_DATA <= head.pix;
        default:         VID_DATA <= '0;
      endcase
    end
  end

  always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
    if (!AXIS_VID_ARESETN) begin
      UNDERFLOW   <= 1'b0;
      FRAME_ERR   <= 1'b0;
      resync_pend <= 1'b0;
    end else begin
      UNDERFLOW <= uf_evt | (UNDERFLOW & ~CLR_ERR);
      FRAME_ERR <= fe_evt | (FRAME_ERR & ~CLR_ERR);
      if (soft_rst || !run) resync_pend <= 1'b0;
      else if (uf_evt || fe_evt) resync_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_vid_out.sv
// Directed bench for axis_vid_out on a reduced 8x4 raster.
// H total 15 (sync hx 10..12), V total 8 (sync vy 5..6).
module tb_axis_vid_out;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam logic [23:0] UF = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] TDATA = '0;
  logic        TLAST = 1'b0;
  logic        TUSER = 1'b0;
  logic        TVALID = 1'b0;
  logic        TREADY;
  logic        PIX_CE = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic [23:0] VID_DATA;
  logic        VID_HSYNC;
  logic        VID_VSYNC;
  logic        VID_DE;
  logic        LOCKED;
  logic        UNDERFLOW;
  logic        FRAME_ERR;

  always #5 clk = ~clk;

  axis_vid_out #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .FIFO_SIZE (16), .LOCK_LEVEL (8),
    .UF_COLOR (24'hFF00FF)
  ) dut (
    .AXIS_VID_ACLK    (clk),
    .AXIS_VID_ARESETN (rst_n),
    .AXIS_VID_TDATA   (TDATA),
    .AXIS_VID_TLAST   (TLAST),
    .AXIS_VID_TUSER   (TUSER),
    .AXIS_VID_TVALID  (TVALID),
    .AXIS_VID_TREADY  (TREADY),
    .PIX_CE           (PIX_CE),
    .CLR_ERR          (CLR_ERR),
    .VID_DATA         (VID_DATA),
    .VID_HSYNC        (VID_HSYNC),
    .VID_VSYNC        (VID_VSYNC),
    .VID_DE           (VID_DE),
    .LOCKED           (LOCKED),
    .UNDERFLOW        (UNDERFLOW),
    .FRAME_ERR        (FRAME_ERR)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [25:0] src_q[$];
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  bit          src_en = 0;
  bit          ce_en = 0;
  int          ce_div = 0;
  int          acc_cnt = 0;
  int          mhx = 0;
  int          mvy = 0;
  int          npos = 0;
  int          timing_bad = 0;
  int          hold_bad = 0;
  int          hs_low = 0;
  int          vs_low = 0;
  int          uf_cnt = 0;
  logic [26:0] last_o = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] bt(input int f, input int y,
                                     input int x, input logic s,
                                     input logic e);
    return {s, e, 8'(f + 1), 8'(y), 8'(x)};
  endfunction

  task automatic frame(input int f, input int short_y,
                       input int nl, input bit to_src,
                       input bit to_exp);
    logic [25:0] b;
    int len;
    for (int y = 0; y < nl; y++) begin
      len = (y == short_y) ? HA - 1 : HA;
      for (int x = 0; x < len; x++) begin
        b = bt(f, y, x, (x == 0 && y == 0), (x == len - 1));
        if (to_src) src_q.push_back(b);
        if (to_exp) exp_q.push_back(b[23:0]);
      end
    end
  endtask

  task automatic clr_mon();
    got_q.delete();
    exp_q.delete();
    npos = 0; timing_bad = 0; hold_bad = 0;
    hs_low = 0; vs_low = 0; uf_cnt = 0;
  endtask

  task automatic cyc();
    logic [25:0] b;
    bit acc, lk, ce, e_de, e_hs, e_vs;
    @(negedge clk);
    ce = ce_en && (ce_div == 2);
    ce_div = (ce_div == 2) ? 0 : ce_div + 1;
    PIX_CE = ce;
    if (src_en && src_q.size() > 0) begin
      b = src_q[0];
      {TUSER, TLAST, TDATA} = b;
      TVALID = 1'b1;
    end else begin
      {TUSER, TLAST, TDATA} = '0;
      TVALID = 1'b0;
    end
    #1;
    acc = TVALID && TREADY;
    lk = (LOCKED === 1'b1);
    @(posedge clk);
    #1;
    if (acc) begin
      void'(src_q.pop_front());
      acc_cnt++;
    end
    if (!lk) begin
      mhx = 0;
      mvy = 0;
    end else if (ce) begin
      e_de = (mhx < HA) && (mvy < VA);
      e_hs = !(mhx >= 10 && mhx < 13);
      e_vs = !(mvy >= 5 && mvy < 7);
      if ({VID_DE, VID_HSYNC, VID_VSYNC} !== {e_de, e_hs, e_vs})
        timing_bad++;
      if (VID_HSYNC === 1'b0) hs_low++;
      if (VID_VSYNC === 1'b0) vs_low++;
      if (VID_DE === 1'b1) begin
        got_q.push_back(VID_DATA);
        if (VID_DATA === UF) uf_cnt++;
      end
      npos++;
      if (mhx == 14) begin
        mhx = 0;
        mvy = (mvy == 7) ? 0 : mvy + 1;
      end else begin
        mhx++;
      end
    end else if ({VID_DATA, VID_DE, VID_HSYNC, VID_VSYNC} !== last_o) begin
      hold_bad++;
    end
    last_o = {VID_DATA, VID_DE, VID_HSYNC, VID_VSYNC};
  endtask

  task automatic wait_lock(input string tag);
    int g = 0;
    while (LOCKED !== 1'b1 && g < 1000) begin
      cyc();
      g++;
    end
    chk(tag, LOCKED, 1);
  endtask

  task automatic run_pos(input int n, input string tag);
    int s = npos;
    int g = 0;
    while (npos - s < n && g < n * 3 + 100) begin
      cyc();
      g++;
    end
    chk(tag, npos - s, n);
  endtask

  task automatic cmp_seq(input string tag);
    int bad = 0;
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {TVALID, TUSER, TLAST, TDATA} = '0;
    PIX_CE = 1'b0; CLR_ERR = 1'b0;
    src_en = 0; ce_en = 0;
    src_q.delete();
    clr_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ce_div = 0;
    acc_cnt = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, VID_DATA, 0);
    chk({tag, "_de"}, VID_DE, 0);
    chk({tag, "_hs"}, VID_HSYNC, 1);
    chk({tag, "_vs"}, VID_VSYNC, 1);
    chk({tag, "_locked"}, LOCKED, 0);
    chk({tag, "_uf"}, UNDERFLOW, 0);
    chk({tag, "_fe"}, FRAME_ERR, 0);
  endtask

  initial begin
    logic [25:0] b;
    logic [26:0] frz;

    #12;
    chk_reset_vals("rst");
    chk("rst_tready", TREADY, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // garbage before SOF, then three clean frames
    for (int i = 0; i < 100; i++)
      src_q.push_back({2'b00, 24'hBAD000 + 24'(i)});
    frame(0, -1, VA, 1, 1);
    frame(1, -1, VA, 1, 1);
    frame(2, -1, VA, 1, 0);
    acc_cnt = 0;
    src_en = 1; ce_en = 1;
    wait_lock("lock_a");
    chk("lock_level", acc_cnt - 100, 9);
    run_pos(240, "pos_a");
    b = bt(0, 0, 0, 1, 0);
    chk("first_pix", got_q[0], b[23:0]);
    cmp_seq("seq_a");
    chk("timing_a", timing_bad, 0);
    chk("hs_low_a", hs_low, 48);
    chk("vs_low_a", vs_low, 60);
    chk("uf_a", UNDERFLOW, 0);
    chk("fe_a", FRAME_ERR, 0);

    // freeze the raster: no pops, FIFO fills up
    ce_en = 0;
    frz = last_o;
    repeat (40) cyc();
    chk("frz_tready", TREADY, 0);
    chk("frz_occ", acc_cnt - 100 - got_q.size(), 16);
    chk("frz_out", {VID_DATA, VID_DE, VID_HSYNC, VID_VSYNC}, frz);
    chk("frz_hold", hold_bad, 0);
    ce_en = 1;
    frame(2, -1, VA, 0, 1);
    run_pos(120, "pos_a2");
    cmp_seq("seq_a2");
    chk("timing_a2", timing_bad, 0);

    // source dry: underflow pixels, then async reset mid-line
    run_pos(3, "pos_a3");
    chk("uf_de", VID_DE, 1);
    chk("uf_pix", VID_DATA, UF);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    do_reset();

    // stall after two lines of frame 1
    frame(0, -1, VA, 1, 1);
    frame(1, -1, 2, 1, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(UF);
    src_en = 1; ce_en = 1;
    wait_lock("lock_b");
    run_pos(240, "pos_b");
    cmp_seq("seq_b");
    chk("uf_cnt_b", uf_cnt, 16);
    chk("uf_flag_b", UNDERFLOW, 1);
    chk("fe_b", FRAME_ERR, 0);
    chk("unlock_b", LOCKED, 0);
    chk("timing_b", timing_bad, 0);
    clr_mon();
    frame(2, -1, VA, 1, 1);
    wait_lock("relock_b");
    run_pos(120, "pos_b2");
    cmp_seq("seq_b2");
    chk("uf_sticky", UNDERFLOW, 1);
    chk("locked_b2", LOCKED, 1);
    ce_en = 0;
    CLR_ERR = 1'b1;
    cyc();
    CLR_ERR = 1'b0;
    cyc();
    chk("uf_clr", UNDERFLOW, 0);
    do_reset();

    // line 1 of frame 0 is one beat short
    frame(0, 1, VA, 1, 1);
    b = bt(1, 0, 0, 1, 0);
    exp_q.push_back(b[23:0]);
    frame(1, -1, VA, 1, 0);
    frame(2, -1, VA, 1, 0);
    src_en = 1; ce_en = 1;
    wait_lock("lock_c");
    run_pos(120, "pos_c");
    cmp_seq("seq_c");
    chk("fe_c", FRAME_ERR, 1);
    chk("uf_c", UNDERFLOW, 0);
    chk("unlock_c", LOCKED, 0);
    clr_mon();
    frame(2, -1, VA, 0, 1);
    wait_lock("relock_c");
    run_pos(120, "pos_c2");
    cmp_seq("seq_c2");
    chk("timing_c2", timing_bad, 0);
    chk("fe_sticky", FRAME_ERR, 1);
    ce_en = 0;
    CLR_ERR = 1'b1;
    cyc();
    CLR_ERR = 1'b0;
    cyc();
    chk("fe_clr", FRAME_ERR, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
